// File: rtl/mem_access_stage.sv
// Memory-stage load/store unit: issues data-bus requests, stalls the pipeline
// while the bus is busy, formats store lanes / extends load data, holds MEM/WB.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [1:0]  StoreM,
  input  logic [2:0]  LoadM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] luipacM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RDM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [31:0] luipacW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RDW,
  output logic        stateDbg
);

  // Bus handshake: dmem_req with addr/we/be/wdata is held unchanged from the
  // first request cycle until the cycle dmem_ready=1; that cycle completes the
  // transfer and dmem_rdata is valid only then. ready without req is ignored.

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_t;

  localparam int CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_t          state, nextState;
  logic [CntW-1:0] cnt, cntNext;

  logic        isStore, isLoad, memOp, misaligned;
  size_t       size;
  logic [31:0] issueAddr, issueWdata;
  logic [3:0]  issueBe;

  logic [31:0] latAddr, latWdata;
  logic [3:0]  latBe;
  logic        latWe;
  logic [1:0]  latOff;
  logic [2:0]  latLoad;

  logic        busErrSet, latchReq, complete, drop, weSel;
  logic [1:0]  offSel;
  logic [2:0]  loadSel;
  logic [31:0] shifted, loadData;

  assign stateDbg = (state == WAIT);

  // Decode the EX/MEM op; a store wins when both store and load are flagged.
  always_comb begin
    isStore = MemWriteM;
    isLoad  = (ResultSrcM == 2'b01) && RegWriteM && !MemWriteM;
    memOp   = isStore || isLoad;
    size    = SzWord;
    if (isStore) begin
      case (StoreM)
        2'b00:   size = SzByte;
        2'b01:   size = SzHalf;
        default: size = SzWord;
      endcase
    end else begin
      case (LoadM)
        3'b000, 3'b100: size = SzByte;
        3'b001, 3'b101: size = SzHalf;
        default:        size = SzWord;
      endcase
    end
    misaligned = ((size == SzHalf) && ALUResultM[0]) ||
                 ((size == SzWord) && (ALUResultM[1:0] != 2'b00));
    issueAddr  = {ALUResultM[31:2], 2'b00};
    issueBe    = 4'b1111;
    issueWdata = '0;
    if (isStore) begin
      case (size)
        SzByte: begin
          issueBe    = 4'b0001 << ALUResultM[1:0];
          issueWdata = {4{WriteDataM[7:0]}};
        end
        SzHalf: begin
          issueBe    = ALUResultM[1] ? 4'b1100 : 4'b0011;
          issueWdata = {2{WriteDataM[15:0]}};
        end
        default: begin
          issueBe    = 4'b1111;
          issueWdata = WriteDataM;
        end
      endcase
    end
  end

  always_comb begin
    nextState  = state;
    cntNext    = cnt;
    busErrSet  = 1'b0;
    latchReq   = 1'b0;
    complete   = 1'b0;
    drop       = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_be    = '0;
    dmem_wdata = '0;
    StallM     = 1'b0;
    MisalignM  = 1'b0;
    offSel     = ALUResultM[1:0];
    loadSel    = LoadM;
    weSel      = isStore;
    case (state)
      IDLE: begin
        if (memOp && misaligned) begin
          MisalignM = 1'b1;
          drop      = 1'b1;
        end else if (memOp && BusErrM) begin
          drop = 1'b1;
        end else if (memOp) begin
          dmem_req   = 1'b1;
          dmem_we    = isStore;
          dmem_addr  = issueAddr;
          dmem_be    = issueBe;
          dmem_wdata = issueWdata;
          if (dmem_ready) begin
            complete = 1'b1;
          end else begin
            StallM    = 1'b1;
            latchReq  = 1'b1;
            nextState = WAIT;
            cntNext   = '0;
          end
        end
      end
      WAIT: begin
        // Replay the latched request so the bus never sees EX/MEM changes.
        dmem_req   = 1'b1;
        dmem_we    = latWe;
        dmem_addr  = latAddr;
        dmem_be    = latBe;
        dmem_wdata = latWdata;
        offSel     = latOff;
        loadSel    = latLoad;
        weSel      = latWe;
        if (dmem_ready) begin
          complete  = 1'b1;
          nextState = IDLE;
        end else if (cnt == CntLast) begin
          busErrSet = 1'b1;
          drop      = 1'b1;
          nextState = IDLE;
        end else begin
          StallM  = 1'b1;
          cntNext = cnt + 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
    if (!reset) begin
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_be    = '0;
      dmem_wdata = '0;
      StallM     = 1'b0;
      MisalignM  = 1'b0;
    end
  end

  // Bring the addressed lane down to bit 0, then extend per load type.
  always_comb begin
    shifted = dmem_rdata >> {offSel, 3'b000};
    case (loadSel)
      3'b000:  loadData = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  loadData = {24'b0, shifted[7:0]};
      3'b001:  loadData = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  loadData = {16'b0, shifted[15:0]};
      default: loadData = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      BusErrM  <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
      latBe    <= '0;
      latWe    <= 1'b0;
      latOff   <= '0;
      latLoad  <= '0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
      if (busErrSet) BusErrM <= 1'b1;
      if (latchReq) begin
        latAddr  <= issueAddr;
        latWdata <= issueWdata;
        latBe    <= issueBe;
        latWe    <= isStore;
        latOff   <= ALUResultM[1:0];
        latLoad  <= LoadM;
      end
    end
  end

  // MEM/WB: stalled or dropped ops become all-zero bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      ReadDataW  <= '0;
      ALUResultW <= '0;
      luipacW    <= '0;
      PCPlus4W   <= '0;
      RDW        <= '0;
    end else if (StallM || drop) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      ReadDataW  <= '0;
      ALUResultW <= '0;
      luipacW    <= '0;
      PCPlus4W   <= '0;
      RDW        <= '0;
    end else begin
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      ReadDataW  <= (complete && !weSel) ? loadData : '0;
      ALUResultW <= ALUResultM;
      luipacW    <= luipacM;
      PCPlus4W   <= PCPlus4M;
      RDW        <= RDM;
    end
  end

endmodule
